// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide RAM between an instruction-fetch port
// and a load/store port. Transfers move one byte per cycle, little-endian.
// The RAM has one cycle of read latency, so reads run one extra BUSY cycle
// to collect the final byte.
module mem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_read,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic        is_mem_q, is_mem_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [1:0]  prev_byte_s;

  // Byte count of a load/store; sizes 10 and 11 are both full words.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'b00:   len_to_n = 3'd1;
      2'b01:   len_to_n = 3'd2;
      default: len_to_n = 3'd4;
    endcase
  endfunction

  // The byte returned by the RAM this cycle belongs to the previous address.
  assign prev_byte_s = cnt_q[1:0] - 2'd1;
  assign if_data     = if_data_q;
  assign mem_rdata   = mem_rdata_q;

  // Next-state, datapath and RAM/ready output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    is_mem_d    = is_mem_q;
    is_wr_d     = is_wr_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_addr    = 32'd0;
    ram_wr      = 1'b0;
    ram_dout    = 8'd0;
    if_ready    = 1'b0;
    mem_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        buf_d = 32'd0;
        if (mem_write) begin
          // A simultaneous read and write is served as a write.
          is_mem_d = 1'b1;
          is_wr_d  = 1'b1;
          base_d   = mem_addr;
          n_d      = len_to_n(mem_len);
          wdata_d  = mem_wdata;
          state_d  = BUSY;
        end else if (mem_read) begin
          is_mem_d = 1'b1;
          is_wr_d  = 1'b0;
          base_d   = mem_addr;
          n_d      = len_to_n(mem_len);
          state_d  = BUSY;
        end else if (if_read) begin
          is_mem_d = 1'b0;
          is_wr_d  = 1'b0;
          base_d   = if_addr;
          n_d      = 3'd4;
          state_d  = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (is_wr_q) begin
          ram_addr = base_q + {29'd0, cnt_q};
          ram_wr   = 1'b1;
          ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == n_q - 3'd1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end else begin
          if (cnt_q < n_q) begin
            ram_addr = base_q + {29'd0, cnt_q};
          end else begin
            ram_addr = 32'd0;
          end
          if (cnt_q != 3'd0) begin
            buf_d[{prev_byte_s, 3'b000} +: 8] = ram_din;
          end else begin
            buf_d = buf_q;
          end
          if (cnt_q == n_q) begin
            state_d = DONE;
            if (is_mem_q) begin
              mem_rdata_d = buf_d;
            end else begin
              if_data_d = buf_d;
            end
          end else begin
            cnt_d   = cnt_q + 3'd1;
            state_d = BUSY;
          end
        end
      end
      DONE: begin
        if_ready  = ~is_mem_q;
        mem_ready = is_mem_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      is_mem_q    <= 1'b0;
      is_wr_q     <= 1'b0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      is_mem_q    <= is_mem_d;
      is_wr_q     <= is_wr_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector table plus hand-written reset/contention/abort
// sequences for mem_ctrl, with a 4 KiB registered-read RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_read, mem_read, mem_write;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        if_ready, mem_ready, ram_wr;
  logic [31:0] if_data, mem_rdata, ram_addr;
  logic [7:0]  ram_dout, ram_din;

  logic [7:0]  ram [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [7:0]  pre_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        fe;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [0:11];

  mem_ctrl dut (
    .clk(clk), .reset(reset),
    .if_read(if_read), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, bench preload port takes precedence.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
    ram_din <= ram[ram_addr[11:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " ram_addr"}, ram_addr, 32'd0);
    check({tag, " ram_wr"}, {31'd0, ram_wr}, 32'd0);
    check({tag, " ram_dout"}, {24'd0, ram_dout}, 32'd0);
    check({tag, " if_ready"}, {31'd0, if_ready}, 32'd0);
    check({tag, " mem_ready"}, {31'd0, mem_ready}, 32'd0);
    check({tag, " if_data"}, if_data, 32'd0);
    check({tag, " mem_rdata"}, mem_rdata, 32'd0);
  endtask

  // Run one transaction from an IDLE cycle; checks RAM bus every BUSY cycle
  // and the ready pulse at exactly the hand-computed latency.
  task automatic apply(input string tag, input vec_t v);
    int n;
    logic fetch_only;
    logic [31:0] exp_a;
    fetch_only = v.fe & ~v.wr & ~v.rd;
    n = fetch_only ? 4 : (v.len == 2'b00) ? 1 : (v.len == 2'b01) ? 2 : 4;
    if_read = v.fe; if_addr = v.addr;
    mem_read = v.rd; mem_write = v.wr; mem_addr = v.addr;
    mem_len = v.len; mem_wdata = v.wdata;
    for (int c = 1; c <= v.exp_lat; c++) begin
      tick();
      check($sformatf("%s c%0d if_ready", tag, c), {31'd0, if_ready},
            {31'd0, (c == v.exp_lat) && fetch_only});
      check($sformatf("%s c%0d mem_ready", tag, c), {31'd0, mem_ready},
            {31'd0, (c == v.exp_lat) && !fetch_only});
      if (c < v.exp_lat) begin
        if (c - 1 < n) begin
          exp_a = v.addr + (c - 1);
          check($sformatf("%s c%0d ram_addr", tag, c), ram_addr, exp_a);
          check($sformatf("%s c%0d ram_wr", tag, c), {31'd0, ram_wr}, {31'd0, v.wr});
          if (v.wr) begin
            exp_a = v.wdata >> (8 * (c - 1));
            check($sformatf("%s c%0d ram_dout", tag, c), {24'd0, ram_dout}, {24'd0, exp_a[7:0]});
          end
        end else begin
          check($sformatf("%s c%0d ram_addr tail", tag, c), ram_addr, 32'd0);
        end
      end else begin
        check($sformatf("%s done ram_wr", tag), {31'd0, ram_wr}, 32'd0);
        if (fetch_only) check($sformatf("%s if_data", tag), if_data, v.exp_data);
        else if (!v.wr) check($sformatf("%s mem_rdata", tag), mem_rdata, v.exp_data);
      end
    end
    if_read = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    tick();
    check($sformatf("%s pulse end", tag), {30'd0, if_ready, mem_ready}, 32'd0);
  endtask

  initial begin
    vec_t v;
    logic [1:0] exp_rdy;
    reset = 1'b1; pre_we = 1'b0; pre_addr = 12'd0; pre_data = 8'd0;
    if_read = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if_addr = 32'd0; mem_addr = 32'd0; mem_len = 2'd0; mem_wdata = 32'd0;

    //           wr    rd    fe    len    addr           wdata          exp_data       lat
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0100, 32'h0,         32'h0010_0513, 6};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,         3};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'h0,         32'h8877_BEEF, 6};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0202, 32'h0,         32'h0000_8877, 4};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0300, 32'h0,         32'h0000_0080, 3};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0500, 32'h0102_0304, 32'h0,         5};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0501, 32'hAABB_CCFF, 32'h0,         2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_0500, 32'h0,         32'h0102_FF04, 6};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_0600, 32'h0000_1234, 32'h0,         3};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0600, 32'h0,         32'h0000_1234, 4};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,         32'hD4C3_B2A1, 6};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0200, 32'h0,         32'h8877_BEEF, 6};

    // Preload while held in reset.
    tick();
    preload(12'h100, 8'h13); preload(12'h101, 8'h05);
    preload(12'h102, 8'h10); preload(12'h103, 8'h00);
    preload(12'h200, 8'h55); preload(12'h201, 8'h66);
    preload(12'h202, 8'h77); preload(12'h203, 8'h88);
    preload(12'h300, 8'h80);
    preload(12'h400, 8'h11); preload(12'h401, 8'h11);
    preload(12'h402, 8'h11); preload(12'h403, 8'h11);
    preload(12'hFFE, 8'hA1); preload(12'hFFF, 8'hB2);
    preload(12'h000, 8'hC3); preload(12'h001, 8'hD4);
    check_outputs_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
      if (i == 1) begin
        check("half store 0x200", {24'd0, ram[12'h200]}, 32'h0000_00EF);
        check("half store 0x201", {24'd0, ram[12'h201]}, 32'h0000_00BE);
        check("half store 0x202 kept", {24'd0, ram[12'h202]}, 32'h0000_0077);
      end
    end

    // Contention: mem served first (ready c3), fetch sampled at c4, ready c10.
    if_read = 1'b1; if_addr = 32'h100;
    mem_read = 1'b1; mem_addr = 32'h300; mem_len = 2'b00;
    for (int c = 1; c <= 11; c++) begin
      tick();
      exp_rdy = {c == 10, c == 3};
      check($sformatf("contend c%0d readies", c), {30'd0, if_ready, mem_ready}, {30'd0, exp_rdy});
      if (c == 3) begin
        check("contend mem_rdata", mem_rdata, 32'h0000_0080);
        mem_read = 1'b0;
      end
      if (c == 10) begin
        check("contend if_data", if_data, 32'h0010_0513);
        check("contend mem_rdata held", mem_rdata, 32'h0000_0080);
        if_read = 1'b0;
      end
    end

    // Abort: reset after the second byte of a word store to 0x400.
    mem_write = 1'b1; mem_addr = 32'h400; mem_len = 2'b10; mem_wdata = 32'hCAFE_BABE;
    tick();
    tick();
    tick();
    check("abort busy ram_addr", ram_addr, 32'h0000_0402);
    reset = 1'b1;
    #1;
    check_outputs_zero("abort");
    mem_write = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("abort hold c%0d", c), {30'd0, if_ready, mem_ready, ram_wr}, 32'd0);
    end
    reset = 1'b0;
    tick();
    check("abort ram 0x400", {24'd0, ram[12'h400]}, 32'h0000_00BE);
    check("abort ram 0x401", {24'd0, ram[12'h401]}, 32'h0000_00BA);
    check("abort ram 0x402", {24'd0, ram[12'h402]}, 32'h0000_0011);
    check("abort ram 0x403", {24'd0, ram[12'h403]}, 32'h0000_0011);
    v = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0400, 32'h0, 32'h1111_BABE, 6};
    apply("post-abort load", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters: none; address width fixed at 32, RAM data width fixed at 8.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 if_read  input  1  instruction fetch request, level, held until if_ready.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_ready  output  1  one-cycle pulse: if_data valid.
REQ-007 if_data  output  32  fetched word, little-endian.
REQ-008 mem_read  input  1  data load request, level.
REQ-009 mem_write  input  1  data store request, level.
REQ-010 mem_addr  input  32  load/store byte address.
REQ-011 mem_len  input  2  access size: 00 byte, 01 half, 10 or 11 word.
REQ-012 mem_wdata  input  32  store data, low bytes used per mem_len.
REQ-013 mem_ready  output  1  one-cycle pulse: load data valid or store complete.
REQ-014 mem_rdata  output  32  load data, zero-filled above the accessed size.
REQ-015 ram_addr  output  32  RAM byte address.
REQ-016 ram_wr  output  1  1 = write ram_dout at ram_addr on this edge.
REQ-017 ram_dout  output  8  RAM write byte.
REQ-018 ram_din  input  8  RAM read byte; valid the cycle after its address is presented.

Function
REQ-019 The controller SHALL share the single byte-wide RAM between the fetch port and the data port using states IDLE, BUSY, DONE.
REQ-020 In IDLE the controller SHALL sample requests with priority mem_write > mem_read > if_read, latching port, address, size (N = 1/2/4; fetch N = 4) and write data, then enter BUSY with byte counter cnt = 0.
REQ-021 Read in BUSY: for cnt < N, ram_addr SHALL be base+cnt with ram_wr=0; at cnt >= 1 ram_din SHALL be captured into byte cnt-1; at cnt = N, ram_addr SHALL be 0, the last byte is captured and the state becomes DONE (BUSY lasts N+1 cycles).
REQ-022 Write in BUSY: for cnt < N, ram_addr = base+cnt, ram_wr = 1, ram_dout = wdata[8cnt+7:8cnt]; after cnt = N-1 the state becomes DONE (BUSY lasts N cycles).
REQ-023 In DONE the served port's ready SHALL be 1 for exactly that cycle; the next state SHALL be IDLE, and no request is sampled in DONE.
REQ-024 Latency, counted from the IDLE cycle in which a request is sampled (t0): reads pulse ready at t0+N+2; writes at t0+N+1.
REQ-025 if_data / mem_rdata SHALL update only in DONE of their own port and hold between completions; mem_rdata upper unused bytes SHALL be 0.
REQ-026 Address arithmetic SHALL wrap modulo 2^32 (0xFFFFFFFF+1 = 0x00000000).
REQ-027 Request inputs changing or dropping during BUSY SHALL NOT affect the transaction; it completes on latched values and ready still pulses.
REQ-028 mem_read and mem_write asserted together SHALL be served as a write.
REQ-029 Outside BUSY, ram_wr SHALL be 0, ram_addr 0, ram_dout 0; if_ready and mem_ready SHALL never be 1 in the same cycle.

Reset
REQ-030 While reset is 1 the state SHALL be IDLE, cnt 0, all outputs 0, asynchronously.
REQ-031 Reset mid-BUSY SHALL abort the transaction without a ready pulse; RAM bytes written before reset remain, no further ram_wr.

Verification
REQ-032 Fetch: RAM[0x100..0x103] = 13,05,10,00, if_read=1, if_addr=0x100 -> ram_addr 0x100..0x103 consecutively, if_ready single pulse at t0+6, if_data = 0x00100513.
REQ-033 Store half: mem_write=1, mem_len=01, mem_addr=0x200, mem_wdata=0xDEADBEEF -> ram_wr=1 two cycles, (0x200,EF),(0x201,BE); mem_ready at t0+3; RAM[0x202] unchanged.
REQ-034 Contention: if_read and mem_read (len 00, addr 0x300, RAM=0x80) raised same cycle -> mem served first, mem_rdata = 0x00000080 at t0+3; fetch sampled next IDLE, if_ready after; no overlapping ready.
REQ-035 Wrap: word load at 0xFFFFFFFE -> ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-036 Abort: reset asserted after second byte of word store to 0x400 -> outputs 0 immediately, only RAM[0x400],[0x401] written, no mem_ready; next request after reset served normally.
